denoise_top_hls_deadlock_report_ctrl: RTL and testbench



---
 rtl/denoise_top_hls_deadlock_report_ctrl_if.sv | 29 ++
 rtl/denoise_top_hls_deadlock_report_ctrl.sv | 150 +++++++++++++++
 tb/tb_denoise_top_hls_deadlock_report_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/denoise_top_hls_deadlock_report_ctrl_if.sv
// Bundle between the deadlock report sequencer and the per-process detect units / host debug path.
// The master side is the sequencer; the slave side is everything it talks to.
interface denoise_top_hls_deadlock_report_ctrl_if #(
    parameter int PROC_NUM = 4,
    parameter int ID_W     = 2
);
    logic [PROC_NUM-1:0] dl_detect_in_vec;
    logic [PROC_NUM-1:0] token_seen_vec;
    logic                clr_report;
    logic [PROC_NUM-1:0] origin_vec;
    logic                dl_detect_bcast;
    logic                token_clear;
    logic                report_valid;
    logic [PROC_NUM-1:0] report_mask;
    logic [ID_W-1:0]     report_origin;
    logic                report_timeout;

    modport master (
        input  dl_detect_in_vec, token_seen_vec, clr_report,
        output origin_vec, dl_detect_bcast, token_clear,
               report_valid, report_mask, report_origin, report_timeout
    );

    modport slave (
        output dl_detect_in_vec, token_seen_vec, clr_report,
        input  origin_vec, dl_detect_bcast, token_clear,
               report_valid, report_mask, report_origin, report_timeout
    );
endinterface

// File: rtl/denoise_top_hls_deadlock_report_ctrl.sv
// Deadlock report sequencer: filters unit detect flags, elects a round-robin token origin,
// traces the token around the dependency cycle and holds a sticky report until acknowledged.
module denoise_top_hls_deadlock_report_ctrl #(
    parameter int PROC_NUM       = 4,
    parameter int ID_W           = 2,
    parameter int CONFIRM_CYCLES = 4,
    parameter int TRACE_TIMEOUT  = 64
) (
    input  logic clock,
    input  logic reset,
    denoise_top_hls_deadlock_report_ctrl_if.master bus
);

    localparam int CONF_W  = $clog2(CONFIRM_CYCLES + 1);
    localparam int TRACE_W = $clog2(TRACE_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ORIGIN, TRACE, REPORT} state_t;

    state_t              state;
    state_t              state_next;
    logic [CONF_W-1:0]   confirm_cnt;
    logic [TRACE_W-1:0]  trace_cnt;
    logic [ID_W-1:0]     origin_id;
    logic [ID_W-1:0]     last_origin;
    logic [PROC_NUM-1:0] report_mask_q;
    logic                report_timeout_q;

    logic                any_detect;
    logic                confirmed;
    logic                token_ret;
    logic                trace_to;
    logic [ID_W-1:0]     elect_id;
    logic                elect_found;

    assign any_detect = |bus.dl_detect_in_vec;
    assign confirmed  = any_detect && (confirm_cnt == CONF_W'(CONFIRM_CYCLES - 1));
    assign token_ret  = bus.token_seen_vec[origin_id];
    assign trace_to   = (trace_cnt == TRACE_W'(TRACE_TIMEOUT - 1));

    assign bus.report_mask    = report_mask_q;
    assign bus.report_origin  = origin_id;
    assign bus.report_timeout = report_timeout_q;

    // Round-robin pick: first detecting process above last_origin, else wrap and take the lowest.
    always_comb begin
        elect_id    = '0;
        elect_found = 1'b0;
        for (int i = 0; i < PROC_NUM; i++) begin
            if (!elect_found && bus.dl_detect_in_vec[i] && (ID_W'(i) > last_origin)) begin
                elect_id    = ID_W'(i);
                elect_found = 1'b1;
            end
        end
        for (int i = 0; i < PROC_NUM; i++) begin
            if (!elect_found && bus.dl_detect_in_vec[i]) begin
                elect_id    = ID_W'(i);
                elect_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next          = state;
        bus.origin_vec      = '0;
        bus.dl_detect_bcast = 1'b0;
        bus.token_clear     = 1'b0;
        bus.report_valid    = 1'b0;
        case (state)
            IDLE: begin
                if (confirmed) begin
                    state_next = ORIGIN;
                end
            end
            ORIGIN: begin
                bus.origin_vec      = PROC_NUM'(1) << origin_id;
                bus.dl_detect_bcast = 1'b1;
                state_next          = TRACE;
            end
            TRACE: begin
                bus.dl_detect_bcast = 1'b1;
                // The kill must reach the units in the same cycle the return or timeout is seen.
                if (token_ret || trace_to) begin
                    bus.token_clear = 1'b1;
                    state_next      = REPORT;
                end
            end
            REPORT: begin
                bus.dl_detect_bcast = 1'b1;
                bus.report_valid    = 1'b1;
                if (bus.clr_report) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            confirm_cnt      <= '0;
            trace_cnt        <= '0;
            origin_id        <= '0;
            last_origin      <= ID_W'(PROC_NUM - 1);
            report_mask_q    <= '0;
            report_timeout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (confirmed) begin
                        origin_id        <= elect_id;
                        last_origin      <= elect_id;
                        report_mask_q    <= PROC_NUM'(1) << elect_id;
                        report_timeout_q <= 1'b0;
                        trace_cnt        <= '0;
                        confirm_cnt      <= '0;
                    end else if (any_detect) begin
                        confirm_cnt <= confirm_cnt + CONF_W'(1);
                    end else begin
                        confirm_cnt <= '0;
                    end
                end
                TRACE: begin
                    report_mask_q <= report_mask_q | bus.token_seen_vec;
                    if (trace_cnt != '1) begin
                        trace_cnt <= trace_cnt + TRACE_W'(1);
                    end
                    // A return beats a simultaneous timeout.
                    if (token_ret || trace_to) begin
                        report_timeout_q <= trace_to & ~token_ret;
                    end
                end
                REPORT: begin
                    if (bus.clr_report) begin
                        confirm_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_denoise_top_hls_deadlock_report_ctrl.sv
// Directed bench for the deadlock report sequencer: an event-level reference model is checked
// against the DUT every cycle, with hand-computed literal checks pinning the key scenarios.
module tb_denoise_top_hls_deadlock_report_ctrl;

    localparam int PROC_NUM       = 4;
    localparam int ID_W           = 2;
    localparam int CONFIRM_CYCLES = 4;
    localparam int TRACE_TIMEOUT  = 64;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    denoise_top_hls_deadlock_report_ctrl_if #(.PROC_NUM(PROC_NUM), .ID_W(ID_W)) ifc ();

    denoise_top_hls_deadlock_report_ctrl #(
        .PROC_NUM(PROC_NUM), .ID_W(ID_W),
        .CONFIRM_CYCLES(CONFIRM_CYCLES), .TRACE_TIMEOUT(TRACE_TIMEOUT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(ifc.master)
    );

    int check_cnt = 0;
    int pass_cnt  = 0;
    bit model_on  = 1'b0;

    // Event-level reference: a detect streak leads to one origin pulse, a trace, then a held report.
    int                  m_streak;
    int                  m_last;
    int                  m_origin;
    int                  m_age;
    bit                  m_origin_pulse;
    bit                  m_tracing;
    bit                  m_reporting;
    logic [PROC_NUM-1:0] m_mask;
    bit                  m_timeout;

    function automatic int elect(input logic [PROC_NUM-1:0] det, input int last);
        int r = 0;
        bit f = 1'b0;
        for (int k = 1; k <= PROC_NUM; k++) begin
            if (!f && det[(last + k) % PROC_NUM]) begin
                r = (last + k) % PROC_NUM;
                f = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(posedge clock) begin
        if (reset) begin
            m_streak <= 0; m_last <= PROC_NUM - 1; m_origin <= 0; m_age <= 0;
            m_origin_pulse <= 1'b0; m_tracing <= 1'b0; m_reporting <= 1'b0;
            m_mask <= '0; m_timeout <= 1'b0;
        end else if (m_origin_pulse) begin
            m_origin_pulse <= 1'b0;
            m_tracing      <= 1'b1;
        end else if (m_tracing) begin
            m_mask <= m_mask | ifc.token_seen_vec;
            m_age  <= m_age + 1;
            if (ifc.token_seen_vec[m_origin] || m_age == TRACE_TIMEOUT - 1) begin
                m_tracing   <= 1'b0;
                m_reporting <= 1'b1;
                m_timeout   <= !ifc.token_seen_vec[m_origin];
            end
        end else if (m_reporting) begin
            if (ifc.clr_report) begin
                m_reporting <= 1'b0;
                m_streak    <= 0;
            end
        end else if (|ifc.dl_detect_in_vec) begin
            if (m_streak + 1 == CONFIRM_CYCLES) begin
                m_origin       <= elect(ifc.dl_detect_in_vec, m_last);
                m_last         <= elect(ifc.dl_detect_in_vec, m_last);
                m_mask         <= PROC_NUM'(1) << elect(ifc.dl_detect_in_vec, m_last);
                m_timeout      <= 1'b0;
                m_age          <= 0;
                m_streak       <= 0;
                m_origin_pulse <= 1'b1;
            end else begin
                m_streak <= m_streak + 1;
            end
        end else begin
            m_streak <= 0;
        end
    end

    always @(negedge clock) begin
        if (model_on) begin
            checkOutput("origin_vec", 32'(ifc.origin_vec),
                        m_origin_pulse ? (32'd1 << m_origin) : 32'd0);
            checkOutput("dl_detect_bcast", 32'(ifc.dl_detect_bcast),
                        32'(m_origin_pulse || m_tracing || m_reporting));
            checkOutput("token_clear", 32'(ifc.token_clear),
                        32'(m_tracing && (ifc.token_seen_vec[m_origin] || m_age == TRACE_TIMEOUT - 1)));
            checkOutput("report_valid", 32'(ifc.report_valid), 32'(m_reporting));
            checkOutput("report_mask", 32'(ifc.report_mask), 32'(m_mask));
            checkOutput("report_origin", 32'(ifc.report_origin), m_origin);
            checkOutput("report_timeout", 32'(ifc.report_timeout), 32'(m_timeout));
        end
    end

    task automatic applyStimulus(input logic [PROC_NUM-1:0] det, input logic [PROC_NUM-1:0] tok,
                                 input logic clr, input logic rst);
        @(posedge clock);
        #1;
        ifc.dl_detect_in_vec = det;
        ifc.token_seen_vec   = tok;
        ifc.clr_report       = clr;
        reset                = rst;
        @(negedge clock);
    endtask

    task automatic runEvent(input logic [PROC_NUM-1:0] det, input int exp_origin);
        for (int c = 0; c < CONFIRM_CYCLES; c++) begin
            applyStimulus(det, 4'b0000, 1'b0, 1'b0);
            checkOutput("ev_wait_origin", 32'(ifc.origin_vec), 32'd0);
        end
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
        checkOutput("ev_origin_vec", 32'(ifc.origin_vec), 32'd1 << exp_origin);
        applyStimulus(4'b0000, 4'(32'd1 << exp_origin), 1'b0, 1'b0);
        checkOutput("ev_token_clear", 32'(ifc.token_clear), 32'd1);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
        checkOutput("ev_report_valid", 32'(ifc.report_valid), 32'd1);
        checkOutput("ev_report_origin", 32'(ifc.report_origin), 32'(exp_origin));
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
        checkOutput("ev_valid_fall", 32'(ifc.report_valid), 32'd0);
    endtask

    logic [PROC_NUM-1:0] trace_tok [4];

    initial begin
        ifc.dl_detect_in_vec = '0;
        ifc.token_seen_vec   = '0;
        ifc.clr_report       = 1'b0;
        trace_tok = '{4'b0000, 4'b1000, 4'b0001, 4'b0100};

        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b1);
        model_on = 1'b1;
        checkOutput("reset_bcast", 32'(ifc.dl_detect_bcast), 32'd0);
        checkOutput("reset_mask", 32'(ifc.report_mask), 32'd0);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);

        // Round-robin from the reset value of last_origin: 1, then 3, then back to 1.
        runEvent(4'b1010, 1);
        runEvent(4'b1010, 3);
        runEvent(4'b1010, 1);

        for (int i = 0; i <= CONFIRM_CYCLES; i++) begin
            applyStimulus(4'b0100, 4'b0000, 1'b0, 1'b0);
            checkOutput("def_origin_vec", 32'(ifc.origin_vec), (i == 4) ? 32'h4 : 32'h0);
            checkOutput("def_bcast", 32'(ifc.dl_detect_bcast), (i == 4) ? 32'd1 : 32'd0);
        end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'b0000, trace_tok[k], 1'b0, 1'b0);
            checkOutput("trace_token_clear", 32'(ifc.token_clear), (k == 3) ? 32'd1 : 32'd0);
        end
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
        checkOutput("trace_valid", 32'(ifc.report_valid), 32'd1);
        checkOutput("trace_mask", 32'(ifc.report_mask), 32'hd);
        checkOutput("trace_timeout", 32'(ifc.report_timeout), 32'd0);
        checkOutput("trace_origin", 32'(ifc.report_origin), 32'd2);
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0);

        // Glitch: the dropped cycle must restart the confirmation count.
        for (int i = 0; i < 8; i++) begin
            applyStimulus((i == 3) ? 4'b0000 : 4'b0010, 4'b0000, 1'b0, 1'b0);
            checkOutput("glitch_no_origin", 32'(ifc.origin_vec), 32'd0);
        end
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
        checkOutput("glitch_origin_vec", 32'(ifc.origin_vec), 32'h2);
        for (int k = 0; k < TRACE_TIMEOUT; k++) begin
            applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
            checkOutput("to_token_clear", 32'(ifc.token_clear), (k == TRACE_TIMEOUT - 1) ? 32'd1 : 32'd0);
        end
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
        checkOutput("to_timeout", 32'(ifc.report_timeout), 32'd1);
        checkOutput("to_mask", 32'(ifc.report_mask), 32'h2);
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0);

        // Abort in the middle of a trace.
        for (int i = 0; i < CONFIRM_CYCLES; i++) applyStimulus(4'b1010, 4'b0000, 1'b0, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
        checkOutput("abort_origin_vec", 32'(ifc.origin_vec), 32'h8);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b1);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
        checkOutput("abort_bcast", 32'(ifc.dl_detect_bcast), 32'd0);
        checkOutput("abort_mask", 32'(ifc.report_mask), 32'd0);
        checkOutput("abort_origin", 32'(ifc.report_origin), 32'd0);
        checkOutput("abort_valid", 32'(ifc.report_valid), 32'd0);
        runEvent(4'b0101, 0);

        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
        model_on = 1'b0;
        $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
